serial_blink_scheduler: RTL and testbench

//  Command scheduler between four_byte_receiver_rx and the LED. Receives 32-bit command

---
 rtl/serial_cmd_pkg.sv | 33 +++
 rtl/cmd_fifo.sv | 58 +++++
 rtl/serial_blink_scheduler.sv | 126 ++++++++++++
 tb/tb_serial_blink_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_cmd_pkg.sv
// Command word format and scheduler state encoding.
// Shared between the LED scheduler and host-side command tooling.
package serial_cmd_pkg;

   localparam int CMD_W   = 32;
   localparam int DUR_W   = 28;
   localparam int OP_W    = 4;
   localparam int OP_MSB  = 31;
   localparam int OP_LSB  = 28;
   localparam int DUR_MSB = 27;
   localparam int DUR_LSB = 0;

   localparam logic [OP_W-1:0] OP_PULSE = 4'h1;
   localparam logic [OP_W-1:0] OP_WAIT  = 4'h2;
   localparam logic [OP_W-1:0] OP_FLUSH = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_PULSE_ON,
      ST_GAP,
      ST_WAIT
   } state_t;

   function automatic logic [OP_W-1:0] cmd_op(input logic [CMD_W-1:0] w);
      return w[OP_MSB:OP_LSB];
   endfunction

   function automatic logic [DUR_W-1:0] cmd_dur(input logic [CMD_W-1:0] w);
      return w[DUR_MSB:DUR_LSB];
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command queue with push/pop/clear and a registered head.
// The head register is loaded on pop, so it holds the entry just removed.
module cmd_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 32
) (
   input  logic                         CLK_25MHZ,
   input  logic                         RSTN,
   input  logic                         push,
   input  logic [W-1:0]                 push_data,
   input  logic                         pop,
   input  logic                         clear,
   output logic [W-1:0]                 head,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count_q;

   // storage array; a simultaneous clear discards the write
   always_ff @(posedge CLK_25MHZ) begin
      if (push && !clear) mem[wr_ptr] <= push_data;
   end

   // pointers, occupancy and head register
   always_ff @(posedge CLK_25MHZ or posedge RSTN) begin
      if (RSTN) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         head    <= '0;
      end else if (clear) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            head   <= mem[rd_ptr];
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push && !pop)      count_q <= count_q + CW'(1);
         else if (pop && !push) count_q <= count_q - CW'(1);
      end
   end

   assign count = count_q;
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

endmodule

// File: rtl/serial_blink_scheduler.sv
// Queues 32-bit LED commands and plays them back as timed pulses/waits.
// Every PULSE is followed by a forced LED-off gap of GAP_CYCLES.
module serial_blink_scheduler #(
   parameter int FIFO_DEPTH = 8,
   parameter int GAP_CYCLES = 6250000,
   parameter int DUR_W      = 28
) (
   input  logic                              CLK_25MHZ,
   input  logic                              RSTN,
   input  logic                              i_Rx_DV,
   input  logic [31:0]                       i_Rx_Four_Bytes,
   output logic                              LEDR,
   output logic                              o_busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_fifo_count,
   output logic                              o_overflow,
   output logic                              o_bad_cmd
);

   import serial_cmd_pkg::*;

   localparam logic [31:0] GAP_LOAD = 32'(GAP_CYCLES - 1);

   state_t            state;
   logic [31:0]       counter;
   logic [OP_W-1:0]   rx_op;
   logic              rx_flush;
   logic              rx_cmd;
   logic              rx_bad;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic              drop_full;
   logic [CMD_W-1:0]  head;
   logic [OP_W-1:0]   head_op;
   logic [DUR_W-1:0]  head_dur;
   logic [31:0]       dur_load;

   assign rx_op    = cmd_op(i_Rx_Four_Bytes);
   assign rx_flush = i_Rx_DV && (rx_op == OP_FLUSH);
   assign rx_cmd   = i_Rx_DV &&
                     ((rx_op == OP_PULSE) || (rx_op == OP_WAIT));
   assign rx_bad   = i_Rx_DV && !rx_flush && !rx_cmd;

   // a full queue still accepts a word when the head leaves on the same edge
   assign fifo_pop  = (state == ST_IDLE) && !fifo_empty && !rx_flush;
   assign fifo_push = rx_cmd && (!fifo_full || fifo_pop);
   assign drop_full = rx_cmd && fifo_full && !fifo_pop;

   assign head_op  = cmd_op(head);
   assign head_dur = head[DUR_W-1:0];
   assign dur_load = {{(32-DUR_W){1'b0}}, head_dur} - 32'd1;

   cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (CMD_W)
   ) u_fifo (
      .CLK_25MHZ (CLK_25MHZ),
      .RSTN      (RSTN),
      .push      (fifo_push),
      .push_data (i_Rx_Four_Bytes),
      .pop       (fifo_pop),
      .clear     (rx_flush),
      .head      (head),
      .count     (o_fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // scheduler FSM, duration counter and registered outputs
   always_ff @(posedge CLK_25MHZ or posedge RSTN) begin
      if (RSTN) begin
         state      <= ST_IDLE;
         counter    <= '0;
         LEDR       <= 1'b0;
         o_overflow <= 1'b0;
         o_bad_cmd  <= 1'b0;
      end else begin
         o_overflow <= drop_full;
         o_bad_cmd  <= rx_bad;
         if (rx_flush) begin
            state   <= ST_IDLE;
            counter <= '0;
            LEDR    <= 1'b0;
         end else begin
            unique case (state)
               ST_IDLE: begin
                  if (fifo_pop) state <= ST_FETCH;
               end
               ST_FETCH: begin
                  if (head_dur == '0) begin
                     state <= ST_IDLE;
                  end else if (head_op == OP_PULSE) begin
                     state   <= ST_PULSE_ON;
                     LEDR    <= 1'b1;
                     counter <= dur_load;
                  end else begin
                     state   <= ST_WAIT;
                     counter <= dur_load;
                  end
               end
               ST_PULSE_ON: begin
                  if (counter == '0) begin
                     state   <= ST_GAP;
                     LEDR    <= 1'b0;
                     counter <= GAP_LOAD;
                  end else begin
                     counter <= counter - 32'd1;
                  end
               end
               ST_GAP, ST_WAIT: begin
                  if (counter == '0) state <= ST_IDLE;
                  else               counter <= counter - 32'd1;
               end
               default: begin
                  state <= ST_IDLE;
                  LEDR  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_serial_blink_scheduler.sv
// Directed bench for serial_blink_scheduler (GAP_CYCLES=4, FIFO_DEPTH=4).
// Per-cycle LED/busy/count history is logged and compared to a trace model.
module tb_serial_blink_scheduler;

   localparam int GAP = 4;
   localparam int DEP = 4;

   logic        clk;
   logic        rstn;
   logic        rx_dv;
   logic [31:0] rx_data;
   logic        ledr;
   logic        busy;
   logic [2:0]  fcount;
   logic        ovf;
   logic        bad;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic       led_log  [0:4095];
   logic       busy_log [0:4095];
   logic [2:0] cnt_log  [0:4095];
   bit         exp_q [$];

   serial_blink_scheduler #(
      .FIFO_DEPTH (DEP),
      .GAP_CYCLES (GAP),
      .DUR_W      (28)
   ) dut (
      .CLK_25MHZ       (clk),
      .RSTN            (rstn),
      .i_Rx_DV         (rx_dv),
      .i_Rx_Four_Bytes (rx_data),
      .LEDR            (ledr),
      .o_busy          (busy),
      .o_fifo_count    (fcount),
      .o_overflow      (ovf),
      .o_bad_cmd       (bad)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      led_log[cyc % 4096]  = ledr;
      busy_log[cyc % 4096] = busy;
      cnt_log[cyc % 4096]  = fcount;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] w);
      rx_dv   = 1'b1;
      rx_data = w;
      @(posedge clk);
      #1;
      rx_dv   = 1'b0;
      rx_data = '0;
   endtask

   // trace model: starts at the FETCH of the first entry
   task automatic exp_start();
      exp_q.delete();
      exp_q.push_back(1'b0);
   endtask

   task automatic exp_entry(input logic [3:0] op, input int dur,
                            input bit first);
      if (!first) begin
         exp_q.push_back(1'b0);
         exp_q.push_back(1'b0);
      end
      if (dur != 0) begin
         if (op == 4'h1) begin
            repeat (dur) exp_q.push_back(1'b1);
            repeat (GAP) exp_q.push_back(1'b0);
         end else begin
            repeat (dur) exp_q.push_back(1'b0);
         end
      end
   endtask

   function automatic logic [31:0] mk(input logic [3:0] op, input int dur);
      return {op, 28'(dur)};
   endfunction

   task automatic test_reset();
      rstn    = 1'b1;
      rx_dv   = 1'b0;
      rx_data = '0;
      repeat (3) tick();
      checks++;
      if (ledr !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_led_busy: got %b%b want 00", ledr, busy);
      end
      checks++;
      if (fcount !== 3'd0 || ovf !== 1'b0 || bad !== 1'b0) begin
         errors++;
         $display("FAIL reset_cnt_pulses: got %0d %b %b want 0 0 0",
                  fcount, ovf, bad);
      end
      @(negedge clk);
      rstn = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_single_pulse();
      int t;
      send(mk(4'h1, 5));
      t = cyc;
      checks++;
      if (fcount !== 3'd1 || ledr !== 1'b0) begin
         errors++;
         $display("FAIL single_push: cnt %0d led %b want 1 0", fcount, ledr);
      end
      exp_start();
      exp_entry(4'h1, 5, 1'b1);
      exp_q.push_back(1'b0);
      repeat (exp_q.size() + 2) tick();
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (led_log[t+1+i] !== exp_q[i]) begin
            errors++;
            $display("FAIL single_led[%0d]: got %b want %b",
                     i, led_log[t+1+i], exp_q[i]);
         end
      end
      checks++;
      if (busy_log[t+1] !== 1'b1 || busy_log[t+10] !== 1'b1 ||
          busy_log[t+11] !== 1'b0) begin
         errors++;
         $display("FAIL single_busy: got %b%b%b want 110",
                  busy_log[t+1], busy_log[t+10], busy_log[t+11]);
      end
   endtask

   task automatic test_back_to_back();
      int t;
      send(mk(4'h1, 3));
      t = cyc;
      send(mk(4'h2, 6));
      send(mk(4'h1, 2));
      exp_start();
      exp_entry(4'h1, 3, 1'b1);
      exp_entry(4'h2, 6, 1'b0);
      exp_entry(4'h1, 2, 1'b0);
      exp_q.push_back(1'b0);
      repeat (exp_q.size() + 2) tick();
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (led_log[t+1+i] !== exp_q[i]) begin
            errors++;
            $display("FAIL b2b_led[%0d]: got %b want %b",
                     i, led_log[t+1+i], exp_q[i]);
         end
      end
      checks++;
      if (cnt_log[t+2] !== 3'd2 || cnt_log[t+10] !== 3'd1 ||
          cnt_log[t+18] !== 3'd0) begin
         errors++;
         $display("FAIL b2b_count: got %0d %0d %0d want 2 1 0",
                  cnt_log[t+2], cnt_log[t+10], cnt_log[t+18]);
      end
      checks++;
      if (busy_log[t+exp_q.size()] !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle_end: busy %b want 0",
                  busy_log[t+exp_q.size()]);
      end
   endtask

   task automatic test_overflow();
      int t;
      send(mk(4'h1, 100));
      t = cyc;
      send(mk(4'h1, 2));
      send(mk(4'h2, 3));
      send(mk(4'h1, 1));
      send(mk(4'h2, 1));
      checks++;
      if (fcount !== 3'd4 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL ovf_fill: cnt %0d ovf %b want 4 0", fcount, ovf);
      end
      send(mk(4'h1, 9));
      checks++;
      if (fcount !== 3'd4 || ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_first: cnt %0d ovf %b want 4 1", fcount, ovf);
      end
      send(mk(4'h2, 9));
      checks++;
      if (fcount !== 3'd4 || ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_second: cnt %0d ovf %b want 4 1", fcount, ovf);
      end
      tick();
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL ovf_not_sticky: ovf %b want 0", ovf);
      end
      exp_start();
      exp_entry(4'h1, 100, 1'b1);
      exp_entry(4'h1, 2, 1'b0);
      exp_entry(4'h2, 3, 1'b0);
      exp_entry(4'h1, 1, 1'b0);
      exp_entry(4'h2, 1, 1'b0);
      exp_q.push_back(1'b0);
      repeat (exp_q.size() + 2) tick();
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (led_log[t+1+i] !== exp_q[i]) begin
            errors++;
            $display("FAIL ovf_led[%0d]: got %b want %b",
                     i, led_log[t+1+i], exp_q[i]);
         end
      end
      checks++;
      if (busy_log[t+exp_q.size()] !== 1'b0 || fcount !== 3'd0) begin
         errors++;
         $display("FAIL ovf_end: busy %b cnt %0d want 0 0",
                  busy_log[t+exp_q.size()], fcount);
      end
   endtask

   task automatic test_flush_bad();
      int t;
      send(mk(4'h1, 50));
      send(mk(4'h2, 2));
      send(mk(4'h2, 3));
      send(mk(4'h1, 4));
      send(mk(4'h7, 5));
      checks++;
      if (bad !== 1'b1 || fcount !== 3'd3) begin
         errors++;
         $display("FAIL bad_cmd: bad %b cnt %0d want 1 3", bad, fcount);
      end
      tick();
      checks++;
      if (bad !== 1'b0 || ledr !== 1'b1) begin
         errors++;
         $display("FAIL bad_clear: bad %b led %b want 0 1", bad, ledr);
      end
      send(32'hF000_0000);
      t = cyc;
      checks++;
      if (ledr !== 1'b0 || fcount !== 3'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL flush_now: led %b cnt %0d busy %b want 0 0 0",
                  ledr, fcount, busy);
      end
      checks++;
      if (bad !== 1'b0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL flush_pulses: bad %b ovf %b want 0 0", bad, ovf);
      end
      repeat (30) tick();
      for (int i = 1; i < 30; i++) begin
         checks++;
         if (led_log[t+i] !== 1'b0 || busy_log[t+i] !== 1'b0) begin
            errors++;
            $display("FAIL flush_quiet[%0d]: led %b busy %b want 0 0",
                     i, led_log[t+i], busy_log[t+i]);
         end
      end
   endtask

   task automatic test_zero_dur();
      int t;
      send(mk(4'h1, 0));
      t = cyc;
      send(mk(4'h1, 1));
      exp_start();
      exp_entry(4'h1, 0, 1'b1);
      exp_entry(4'h1, 1, 1'b0);
      exp_q.push_back(1'b0);
      repeat (exp_q.size() + 2) tick();
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (led_log[t+1+i] !== exp_q[i]) begin
            errors++;
            $display("FAIL zero_led[%0d]: got %b want %b",
                     i, led_log[t+1+i], exp_q[i]);
         end
      end
      checks++;
      if (busy_log[t+2] !== 1'b0 || busy_log[t+exp_q.size()] !== 1'b0) begin
         errors++;
         $display("FAIL zero_busy: got %b %b want 0 0",
                  busy_log[t+2], busy_log[t+exp_q.size()]);
      end
   endtask

   task automatic test_async_reset();
      int t;
      send(mk(4'h1, 40));
      send(mk(4'h2, 5));
      send(mk(4'h1, 5));
      repeat (3) tick();
      checks++;
      if (ledr !== 1'b1 || fcount !== 3'd2) begin
         errors++;
         $display("FAIL rst_pre: led %b cnt %0d want 1 2", ledr, fcount);
      end
      #2;
      rstn = 1'b1;
      #1;
      checks++;
      if (ledr !== 1'b0 || busy !== 1'b0 || fcount !== 3'd0) begin
         errors++;
         $display("FAIL rst_async: led %b busy %b cnt %0d want 0 0 0",
                  ledr, busy, fcount);
      end
      repeat (2) tick();
      @(negedge clk);
      rstn = 1'b0;
      tick();
      send(mk(4'h1, 2));
      t = cyc;
      exp_start();
      exp_entry(4'h1, 2, 1'b1);
      exp_q.push_back(1'b0);
      repeat (exp_q.size() + 2) tick();
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (led_log[t+1+i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rst_after_led[%0d]: got %b want %b",
                     i, led_log[t+1+i], exp_q[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_pulse();
      test_back_to_back();
      test_overflow();
      test_flush_bad();
      test_zero_dur();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
